glb_cfg_reg_router: RTL and testbench

- Parametrised successor to the single-channel config register port.
- Takes one host config request stream (write and read buses) and decodes a channel-select field from the address.
- Drives NUM_CH per-channel config register ports with clock-enable lead, single-outstanding read tracking, read timeout/error return and optional write broadcast.
- Sits between the AXI-lite config controller and the GLB tile register files.

---
 rtl/glb_cfg_reg_router.sv | 218 +++++++++++++++++++++
 tb/tb_glb_cfg_reg_router.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/glb_cfg_reg_router.sv
// glb_cfg_reg_router: routes one host config request stream to NUM_CH
// per-channel register ports. Writes go through a 2-stage pipeline whose
// clock enable leads the strobe by one cycle. Reads use a single-outstanding
// FSM with a timeout and an error return.
// Optional feature macro: GLB_CFG_BCAST_EN (an all-ones channel select on a
// write is sent to every channel).
//
// Read FSM states
//   state | meaning
//   IDLE  | no read outstanding, accepts h_rd_en
//   CLK   | clock enable raised on the target channel (or bad sel noted)
//   REQ   | read strobe plus address presented to the target channel
//   WAIT  | waiting for channel valid, timeout counter running
//   RESP  | one-cycle response pulse to the host
module glb_cfg_reg_router #(
  parameter int NUM_CH       = 4,
  parameter int ADDR_WIDTH   = 12,
  parameter int DATA_WIDTH   = 32,
  parameter int CH_SEL_LSB   = 8,
  parameter int CH_SEL_WIDTH = 3,
  parameter int RD_TIMEOUT   = 16
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         h_wr_en,
  input  logic [ADDR_WIDTH-1:0]        h_wr_addr,
  input  logic [DATA_WIDTH-1:0]        h_wr_data,
  input  logic                         h_rd_en,
  input  logic [ADDR_WIDTH-1:0]        h_rd_addr,
  output logic [DATA_WIDTH-1:0]        h_rd_data,
  output logic                         h_rd_data_valid,
  output logic                         h_rd_err,
  output logic                         h_rd_busy,
  output logic [NUM_CH-1:0]            c_wr_en,
  output logic [NUM_CH-1:0]            c_wr_clk_en,
  output logic [ADDR_WIDTH-1:0]        c_wr_addr,
  output logic [DATA_WIDTH-1:0]        c_wr_data,
  output logic [NUM_CH-1:0]            c_rd_en,
  output logic [NUM_CH-1:0]            c_rd_clk_en,
  output logic [ADDR_WIDTH-1:0]        c_rd_addr,
  input  logic [NUM_CH*DATA_WIDTH-1:0] c_rd_data,
  input  logic [NUM_CH-1:0]            c_rd_data_valid
);

`ifdef GLB_CFG_BCAST_EN
  localparam bit BCAST_EN = 1'b1;
`else
  localparam bit BCAST_EN = 1'b0;
`endif

  localparam int CNT_W = $clog2(RD_TIMEOUT);
  localparam logic [CNT_W-1:0]        CNT_LAST = CNT_W'(RD_TIMEOUT - 1);
  localparam logic [CH_SEL_WIDTH:0]   NUM_CH_W = (CH_SEL_WIDTH + 1)'(NUM_CH);
  localparam logic [CH_SEL_WIDTH-1:0] SEL_ALL  = '1;

  typedef enum logic [2:0] {ST_IDLE, ST_CLK, ST_REQ, ST_WAIT, ST_RESP} rd_state_e;

  function automatic logic [NUM_CH-1:0] sel_onehot(input logic [CH_SEL_WIDTH-1:0] sel);
    sel_onehot = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (sel == CH_SEL_WIDTH'(i)) sel_onehot[i] = 1'b1;
    end
  endfunction

  // ---------------- write path ----------------
  logic [CH_SEL_WIDTH-1:0] wr_sel;
  logic [NUM_CH-1:0]       wr_oh_d, wr_s1_oh_q, wr_s2_oh_q;
  logic [ADDR_WIDTH-1:0]   wr_s1_addr_q, wr_addr_q;
  logic [DATA_WIDTH-1:0]   wr_s1_data_q, wr_data_q;

  assign wr_sel = h_wr_addr[CH_SEL_LSB +: CH_SEL_WIDTH];

  // Decode the write target; out-of-range selects give an empty mask (dropped).
  always_comb begin
    wr_oh_d = '0;
    if (h_wr_en) begin
      wr_oh_d = sel_onehot(wr_sel);
      if (BCAST_EN && (wr_sel == SEL_ALL)) wr_oh_d = '1;
    end
  end

  // Two-stage write pipeline; address/data only move with a live write so they hold when idle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_s1_oh_q   <= '0;
      wr_s2_oh_q   <= '0;
      wr_s1_addr_q <= '0;
      wr_s1_data_q <= '0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
    end else begin
      wr_s1_oh_q <= wr_oh_d;
      wr_s2_oh_q <= wr_s1_oh_q;
      if (|wr_oh_d) begin
        wr_s1_addr_q <= h_wr_addr;
        wr_s1_data_q <= h_wr_data;
      end
      if (|wr_s1_oh_q) begin
        wr_addr_q <= wr_s1_addr_q;
        wr_data_q <= wr_s1_data_q;
      end
    end
  end

  assign c_wr_en     = wr_s2_oh_q;
  assign c_wr_clk_en = wr_s1_oh_q | wr_s2_oh_q;
  assign c_wr_addr   = wr_addr_q;
  assign c_wr_data   = wr_data_q;

  // ---------------- read path ----------------
  rd_state_e               state_q, state_d;
  logic [ADDR_WIDTH-1:0]   rd_addr_q, rd_addr_d;
  logic [CH_SEL_WIDTH-1:0] rd_sel_q, rd_sel_d, h_rd_sel;
  logic                    rd_sel_ok_q, rd_sel_ok_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   rd_data_q, rd_data_d, ch_data;
  logic                    rd_err_q, rd_err_d, ch_vld;
  logic [NUM_CH-1:0]       rd_oh;

  assign h_rd_sel = h_rd_addr[CH_SEL_LSB +: CH_SEL_WIDTH];

  // Pick the selected channel's valid and data slice.
  always_comb begin
    ch_vld  = 1'b0;
    ch_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rd_sel_q == CH_SEL_WIDTH'(i)) begin
        ch_vld  = c_rd_data_valid[i];
        ch_data = c_rd_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Read FSM next-state and response capture.
  always_comb begin
    state_d     = state_q;
    rd_addr_d   = rd_addr_q;
    rd_sel_d    = rd_sel_q;
    rd_sel_ok_d = rd_sel_ok_q;
    cnt_d       = cnt_q;
    rd_data_d   = rd_data_q;
    rd_err_d    = rd_err_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (h_rd_en) begin
          rd_addr_d   = h_rd_addr;
          rd_sel_d    = h_rd_sel;
          rd_sel_ok_d = ({1'b0, h_rd_sel} < NUM_CH_W) && !(BCAST_EN && (h_rd_sel == SEL_ALL));
          state_d     = ST_CLK;
        end
      end
      ST_CLK: begin
        if (!rd_sel_ok_q) begin
          rd_data_d = '0;
          rd_err_d  = 1'b1;
          state_d   = ST_RESP;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (ch_vld) begin
          rd_data_d = ch_data;
          rd_err_d  = 1'b0;
          state_d   = ST_RESP;
        end else if (cnt_q == CNT_LAST) begin
          rd_data_d = '0;
          rd_err_d  = 1'b1;
          state_d   = ST_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RESP: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Read FSM state register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      rd_addr_q   <= '0;
      rd_sel_q    <= '0;
      rd_sel_ok_q <= 1'b0;
      cnt_q       <= '0;
      rd_data_q   <= '0;
      rd_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_addr_q   <= rd_addr_d;
      rd_sel_q    <= rd_sel_d;
      rd_sel_ok_q <= rd_sel_ok_d;
      cnt_q       <= cnt_d;
      rd_data_q   <= rd_data_d;
      rd_err_q    <= rd_err_d;
    end
  end

  // Masking with rd_sel_ok_q keeps a bad select from touching any channel.
  assign rd_oh           = sel_onehot(rd_sel_q) & {NUM_CH{rd_sel_ok_q}};
  assign c_rd_clk_en     = (state_q inside {ST_CLK, ST_REQ, ST_WAIT}) ? rd_oh : '0;
  assign c_rd_en         = (state_q == ST_REQ) ? rd_oh : '0;
  assign c_rd_addr       = rd_addr_q;
  assign h_rd_data       = rd_data_q;
  assign h_rd_data_valid = (state_q == ST_RESP);
  assign h_rd_err        = (state_q == ST_RESP) && rd_err_q;
  assign h_rd_busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_glb_cfg_reg_router.sv
// Self-checking bench for glb_cfg_reg_router: scripted scenarios followed by
// random traffic, compared against a transaction-level schedule of expected
// per-cycle outputs.
module tb_glb_cfg_reg_router;
  localparam int NUM_CH = 4, AW = 12, DW = 32, SEL_LSB = 8, SEL_W = 3, TO = 16;
  localparam int NCYC = 3000;
  localparam int SZ   = NCYC + 64;
  localparam int DIRECTED_END = 70;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  reset_n, h_wr_en, h_rd_en;
  logic [AW-1:0]         h_wr_addr, h_rd_addr, c_wr_addr, c_rd_addr;
  logic [DW-1:0]         h_wr_data, h_rd_data, c_wr_data;
  logic                  h_rd_data_valid, h_rd_err, h_rd_busy;
  logic [NUM_CH-1:0]     c_wr_en, c_wr_clk_en, c_rd_en, c_rd_clk_en, c_rd_data_valid;
  logic [NUM_CH*DW-1:0]  c_rd_data;

  glb_cfg_reg_router #(
    .NUM_CH(NUM_CH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .CH_SEL_LSB(SEL_LSB), .CH_SEL_WIDTH(SEL_W), .RD_TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .h_wr_en(h_wr_en), .h_wr_addr(h_wr_addr), .h_wr_data(h_wr_data),
    .h_rd_en(h_rd_en), .h_rd_addr(h_rd_addr), .h_rd_data(h_rd_data),
    .h_rd_data_valid(h_rd_data_valid), .h_rd_err(h_rd_err), .h_rd_busy(h_rd_busy),
    .c_wr_en(c_wr_en), .c_wr_clk_en(c_wr_clk_en), .c_wr_addr(c_wr_addr), .c_wr_data(c_wr_data),
    .c_rd_en(c_rd_en), .c_rd_clk_en(c_rd_clk_en), .c_rd_addr(c_rd_addr),
    .c_rd_data(c_rd_data), .c_rd_data_valid(c_rd_data_valid)
  );

  int n_chk = 0;
  int n_fail = 0;
  int cur_cyc = -1;

  task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", tag, cur_cyc, obs, exp_v);
    end
  endtask

  function automatic int sel_of(input logic [AW-1:0] a);
    return int'((a >> SEL_LSB) & ((1 << SEL_W) - 1));
  endfunction

  function automatic logic [NUM_CH-1:0] wr_mask(input logic [AW-1:0] a);
    int s = sel_of(a);
    logic [NUM_CH-1:0] m = '0;
    if (s < NUM_CH) m = NUM_CH'(1) << s;
`ifdef GLB_CFG_BCAST_EN
    if (s == (1 << SEL_W) - 1) m = '1;
`endif
    return m;
  endfunction

  function automatic bit rd_ok(input logic [AW-1:0] a);
    int s = sel_of(a);
    return (s < NUM_CH) && (s != (1 << SEL_W) - 1);
  endfunction

  // Expected per-cycle outputs, filled in when a request is issued.
  bit [NUM_CH-1:0] e_wen [SZ];
  bit [NUM_CH-1:0] e_wclk[SZ];
  bit [AW-1:0]     e_waddr[SZ];
  bit [DW-1:0]     e_wdata[SZ];
  bit [NUM_CH-1:0] e_ren [SZ];
  bit [NUM_CH-1:0] e_rclk[SZ];
  bit [AW-1:0]     e_raddr[SZ];
  bit              e_rvld[SZ];
  bit              e_rerr[SZ];
  bit [DW-1:0]     e_rdata[SZ];
  bit              e_busy[SZ];
  bit              rst_cyc[SZ];

  int r_prev = -1;
  int wait_lo = 1, wait_hi = 0, plan_cyc = -1, cur_sel = 0;
  logic [DW-1:0] plan_data;
  logic [AW-1:0] hold_waddr = '0;
  logic [DW-1:0] hold_wdata = '0, hold_rdata = '0;

  initial begin
    int lat;
    logic [DW-1:0] force_data;
    bit use_force;
    logic [AW-1:0] ra;
    logic [NUM_CH-1:0] m, noise;

    reset_n = 1'b0; h_wr_en = 1'b1; h_rd_en = 1'b1;
    h_wr_addr = 12'h204; h_wr_data = 32'hDEADBEEF; h_rd_addr = 12'h110;
    c_rd_data = '0; c_rd_data_valid = '0;

    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      chk_eq("rst_c_wr_en", c_wr_en, 0);
      chk_eq("rst_c_wr_clk_en", c_wr_clk_en, 0);
      chk_eq("rst_c_wr_addr", c_wr_addr, 0);
      chk_eq("rst_c_wr_data", c_wr_data, 0);
      chk_eq("rst_c_rd_en", c_rd_en, 0);
      chk_eq("rst_c_rd_clk_en", c_rd_clk_en, 0);
      chk_eq("rst_c_rd_addr", c_rd_addr, 0);
      chk_eq("rst_h_rd_data", h_rd_data, 0);
      chk_eq("rst_h_rd_valid", h_rd_data_valid, 0);
      chk_eq("rst_h_rd_err", h_rd_err, 0);
      chk_eq("rst_h_rd_busy", h_rd_busy, 0);
    end

    for (int c = 0; c < NCYC; c++) begin
      @(posedge clk);
      #1;
      cur_cyc = c;
      reset_n = 1'b1;
      use_force = 1'b0;
      force_data = '0;
      lat = ($urandom_range(0, 3) == 0) ? TO : int'($urandom_range(0, TO - 1));
      if (c < DIRECTED_END) begin
        h_wr_en = 1'b0; h_rd_en = 1'b0;
        h_wr_addr = $urandom; h_wr_data = $urandom; h_rd_addr = $urandom;
        case (c)
          1:  begin h_wr_en = 1'b1; h_wr_addr = 12'h204; h_wr_data = 32'hCAFE0001; end
          4:  begin h_wr_en = 1'b1; h_wr_addr = 12'h010; h_wr_data = 32'hA5A50000; end
          5:  begin h_wr_en = 1'b1; h_wr_addr = 12'h3F0; h_wr_data = 32'h5A5A0003; end
          8:  begin h_rd_en = 1'b1; h_rd_addr = 12'h110; lat = 0;
                    use_force = 1'b1; force_data = 32'h12345678; end
          10: begin h_rd_en = 1'b1; h_rd_addr = 12'h220; end
          15: begin h_rd_en = 1'b1; h_rd_addr = 12'h210; lat = TO; end
          36: begin h_rd_en = 1'b1; h_rd_addr = 12'h500; end
          40: begin h_wr_en = 1'b1; h_wr_addr = 12'h7FC; h_wr_data = 32'h00000001; end
          42: begin h_rd_en = 1'b1; h_rd_addr = 12'h310; lat = TO - 1; end
          62: begin h_wr_en = 1'b1; h_wr_addr = 12'h104; h_wr_data = 32'h0BADF00D;
                    h_rd_en = 1'b1; h_rd_addr = 12'h108; lat = 2; end
          default: ;
        endcase
      end else begin
        h_wr_en = 1'($urandom_range(0, 1));
        h_wr_addr = $urandom;
        h_wr_data = $urandom;
        h_rd_en = ($urandom_range(0, 2) == 0);
        ra = $urandom;
        ra[SEL_LSB +: SEL_W] = SEL_W'($urandom_range(0, 5));
        if ($urandom_range(0, 9) == 0) ra[SEL_LSB +: SEL_W] = '1;
        h_rd_addr = ra;
        if ($urandom_range(0, 199) == 0) reset_n = 1'b0;
      end

      rst_cyc[c] = !reset_n;
      if (!reset_n) begin
        for (int k = c + 1; k <= c + TO + 8; k++) begin
          e_wen[k] = '0; e_wclk[k] = '0; e_ren[k] = '0; e_rclk[k] = '0;
          e_rvld[k] = 1'b0; e_rerr[k] = 1'b0; e_busy[k] = 1'b0;
        end
        r_prev = c; wait_lo = 1; wait_hi = 0; plan_cyc = -1;
      end else begin
        if (h_wr_en) begin
          m = wr_mask(h_wr_addr);
          if (m != 0) begin
            e_wclk[c+1] |= m;
            e_wclk[c+2] |= m;
            e_wen[c+2]  |= m;
            e_waddr[c+2] = h_wr_addr;
            e_wdata[c+2] = h_wr_data;
          end
        end
        if (h_rd_en && c > r_prev) begin
          if (!rd_ok(h_rd_addr)) begin
            r_prev = c + 2;
            e_rvld[r_prev] = 1'b1; e_rerr[r_prev] = 1'b1; e_rdata[r_prev] = '0;
          end else begin
            cur_sel = sel_of(h_rd_addr);
            m = NUM_CH'(1) << cur_sel;
            if (lat < TO) begin
              r_prev = c + 4 + lat;
              plan_cyc = c + 3 + lat;
              plan_data = use_force ? force_data : DW'($urandom);
              e_rvld[r_prev] = 1'b1; e_rerr[r_prev] = 1'b0; e_rdata[r_prev] = plan_data;
            end else begin
              r_prev = c + 3 + TO;
              plan_cyc = -1;
              e_rvld[r_prev] = 1'b1; e_rerr[r_prev] = 1'b1; e_rdata[r_prev] = '0;
            end
            for (int k = c + 1; k < r_prev; k++) e_rclk[k] |= m;
            e_ren[c+2] = m;
            e_raddr[c+2] = h_rd_addr;
            wait_lo = c + 3;
            wait_hi = r_prev - 1;
          end
          for (int k = c + 1; k <= r_prev; k++) e_busy[k] = 1'b1;
        end
      end

      // Channel side: random stray valids, except on the target channel while it is being waited on.
      noise = NUM_CH'($urandom) & NUM_CH'($urandom);
      for (int i = 0; i < NUM_CH; i++) c_rd_data[i*DW +: DW] = $urandom;
      if (c >= wait_lo && c <= wait_hi) noise[cur_sel] = 1'b0;
      if (c == plan_cyc) begin
        noise[cur_sel] = 1'b1;
        c_rd_data[cur_sel*DW +: DW] = plan_data;
      end
      c_rd_data_valid = noise;

      @(negedge clk);
      if (c > 0 && rst_cyc[c-1]) begin
        hold_waddr = '0; hold_wdata = '0; hold_rdata = '0;
      end
      if (e_wen[c] != 0) begin
        hold_waddr = e_waddr[c];
        hold_wdata = e_wdata[c];
      end
      if (e_rvld[c]) hold_rdata = e_rdata[c];

      chk_eq("c_wr_en", c_wr_en, e_wen[c]);
      chk_eq("c_wr_clk_en", c_wr_clk_en, e_wclk[c]);
      chk_eq("c_wr_addr", c_wr_addr, hold_waddr);
      chk_eq("c_wr_data", c_wr_data, hold_wdata);
      chk_eq("c_rd_en", c_rd_en, e_ren[c]);
      chk_eq("c_rd_clk_en", c_rd_clk_en, e_rclk[c]);
      if (e_ren[c] != 0) chk_eq("c_rd_addr", c_rd_addr, e_raddr[c]);
      chk_eq("h_rd_data_valid", h_rd_data_valid, e_rvld[c]);
      chk_eq("h_rd_err", h_rd_err, e_rerr[c]);
      chk_eq("h_rd_busy", h_rd_busy, e_busy[c]);
      chk_eq("h_rd_data", h_rd_data, hold_rdata);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
